imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_timeout.sv | 27 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its host-side model.
package imem_loader_pkg;

  // Frame field widths: 16-bit word count, 8-bit XOR checksum.
  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle timer: counts cycles with no byte while a frame is open.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Fires on the cycle that would be the TIMEOUT_CYCLES-th idle cycle. A byte
  // arriving in that same cycle does not rescue the frame.
  assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter; restarts on every byte and whenever no frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count <= '0;
    else if (!enable || clear || expire) count <= '0;
    else                               count <= count + 1'b1;
  end

endmodule

// File: rtl/imem_loader.sv
// UART-fed instruction-memory loader: parses a framed word stream, writes
// words into instruction memory and holds the CPU while a frame is open.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         MEM_WORDS      = 256,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  state_e              state, state_nxt;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    len_n;
  logic [LEN_W-1:0]    word_idx;
  logic [1:0]          byte_cnt;
  logic [23:0]         word_sh;
  logic [CSUM_W-1:0]   csum;
  logic                expire;
  logic                is_sync;
  logic                len_big;
  logic                last_word;

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (state != ST_IDLE),
    .expire (expire)
  );

  assign is_sync   = (rx_data == SYNC_BYTE);
  assign len_n     = {len[LEN_W-1:8], rx_data};
  assign len_big   = ({16'd0, len_n} > 32'(MEM_WORDS));
  assign last_word = (word_idx == len - 16'd1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a timeout wins over (and discards) a byte in the same cycle.
  always_comb begin
    state_nxt = state;
    if (expire) begin
      state_nxt = ST_IDLE;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE:   if (is_sync) state_nxt = ST_LEN_HI;
        ST_LEN_HI: state_nxt = ST_LEN_LO;
        ST_LEN_LO: begin
          if (len_big)           state_nxt = ST_IDLE;
          else if (len_n == '0)  state_nxt = ST_CHECK;
          else                   state_nxt = ST_DATA;
        end
        ST_DATA:   if (byte_cnt == 2'd3 && last_word) state_nxt = ST_CHECK;
        ST_CHECK:  state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // CPU stays in reset for as long as any frame is open.
  always_comb begin
    cpu_hold = (state != ST_IDLE);
  end

  // Datapath: length capture, word assembly, checksum, write and status strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len       <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      word_sh   <= '0;
      csum      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      if (expire) begin
        load_err <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (is_sync) begin
              load_err <= 1'b0;
              len      <= '0;
              word_idx <= '0;
              byte_cnt <= '0;
              csum     <= '0;
            end
          end
          ST_LEN_HI: len[LEN_W-1:8] <= rx_data;
          ST_LEN_LO: begin
            len[7:0] <= rx_data;
            if (len_big) load_err <= 1'b1;
          end
          ST_DATA: begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            word_sh  <= {word_sh[15:0], rx_data};
            // Fourth byte completes a big-endian word; commit it next cycle.
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= 32'({word_idx, 2'b00});
              wr_data  <= {word_sh, rx_data};
              word_idx <= word_idx + 16'd1;
            end
          end
          ST_CHECK: begin
            if (csum == rx_data) load_done <= 1'b1;
            else                 load_err  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
